l1_cache_nway: RTL and testbench

//  Parametrised N-way set-associative, write-back, write-allocate L1 data cache.

---
 rtl/l1_cache_nway.sv | 201 ++++++++++++++++++++
 tb/tb_l1_cache_nway.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/l1_cache_nway.sv
// N-way set-associative, write-back, write-allocate L1 data cache with true-LRU replacement.
// Optional hit/miss/writeback counters when L1_CACHE_STATS_EN is defined.
module l1_cache_nway #(
  parameter int ADDR_BITS  = 8,
  parameter int WORD_BITS  = 8,
  parameter int OFST_BITS  = 2,
  parameter int INDEX_BITS = 2,
  parameter int WAYS       = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               u_request,
  input  logic                               u_we,
  input  logic [ADDR_BITS-1:0]               u_addr,
  input  logic [WORD_BITS-1:0]               u_din,
  output logic                               u_ready,
  output logic [WORD_BITS-1:0]               u_dout,
  output logic                               d_request,
  output logic                               d_we,
  output logic [ADDR_BITS-OFST_BITS-1:0]     d_addr,
  output logic [(WORD_BITS<<OFST_BITS)-1:0]  d_din,
  input  logic                               d_ready,
  input  logic [(WORD_BITS<<OFST_BITS)-1:0]  d_dout
`ifdef L1_CACHE_STATS_EN
  ,
  output logic [15:0]                        hit_cnt,
  output logic [15:0]                        miss_cnt,
  output logic [15:0]                        wb_cnt
`endif
);
  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - OFST_BITS;
  localparam int SETS     = 1 << INDEX_BITS;
  localparam int WB       = $clog2(WAYS);
  localparam int BLK_W    = WORD_BITS << OFST_BITS;

  typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, FILL} state_t;

  state_t                r_state;
  logic                  r_we;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [WORD_BITS-1:0]  r_din;
  logic [WB-1:0]         r_vict;
  logic                  r_valid [SETS][WAYS];
  logic                  r_dirty [SETS][WAYS];
  logic [WB-1:0]         r_age   [SETS][WAYS];
  logic [TAG_BITS-1:0]   r_tag   [SETS][WAYS];
  logic [BLK_W-1:0]      r_data  [SETS][WAYS];

  logic [TAG_BITS-1:0]   w_tag;
  logic [INDEX_BITS-1:0] w_idx;
  logic [OFST_BITS-1:0]  w_ofst;
  logic                  w_hit, w_has_inv, w_touch;
  logic [WB-1:0]         w_hit_way, w_inv_way, w_lru_way, w_vict, w_touch_way, w_acc_age;

  function automatic logic [BLK_W-1:0] merge_word(input logic [BLK_W-1:0] blk,
                                                  input logic [OFST_BITS-1:0] ofst,
                                                  input logic [WORD_BITS-1:0] word);
    logic [BLK_W-1:0] res;
    res = blk;
    res[int'(ofst)*WORD_BITS +: WORD_BITS] = word;
    return res;
  endfunction

  function automatic logic [WORD_BITS-1:0] get_word(input logic [BLK_W-1:0] blk,
                                                    input logic [OFST_BITS-1:0] ofst);
    return blk[int'(ofst)*WORD_BITS +: WORD_BITS];
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_tag  = r_addr[ADDR_BITS-1 -: TAG_BITS];
  assign w_idx  = r_addr[OFST_BITS +: INDEX_BITS];
  assign w_ofst = r_addr[OFST_BITS-1:0];

  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_has_inv = 1'b0;
    w_inv_way = '0;
    w_lru_way = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WB'(w);
      end
      if (!r_valid[w_idx][w]) begin
        w_has_inv = 1'b1;
        w_inv_way = WB'(w);
      end
      if (r_age[w_idx][w] == WB'(WAYS-1)) w_lru_way = WB'(w);
    end
    w_vict      = w_has_inv ? w_inv_way : w_lru_way;
    w_touch_way = (r_state == LOOKUP) ? w_hit_way : r_vict;
    w_touch     = ((r_state == LOOKUP) && w_hit) || ((r_state == FILL) && d_ready);
    w_acc_age   = r_age[w_idx][w_touch_way];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_we      <= 1'b0;
      r_vict    <= '0;
      u_ready   <= 1'b0;
      u_dout    <= '0;
      d_request <= 1'b0;
      d_we      <= 1'b0;
      d_addr    <= '0;
      d_din     <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
          r_age[s][w]   <= WB'(w);
        end
      end
`ifdef L1_CACHE_STATS_EN
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
`endif
    end else begin
      u_ready   <= 1'b0;
      u_dout    <= '0;
      d_request <= 1'b0;
      if (w_touch) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WB'(w) == w_touch_way)         r_age[w_idx][w] <= '0;
          else if (r_age[w_idx][w] < w_acc_age) r_age[w_idx][w] <= r_age[w_idx][w] + WB'(1);
        end
      end
      case (r_state)
        IDLE: if (u_request) begin
          r_we    <= u_we;
          r_state <= LOOKUP;
        end
        LOOKUP: begin
          if (w_hit) begin
            if (r_we) r_dirty[w_idx][w_hit_way] <= 1'b1;
            else      u_dout <= get_word(r_data[w_idx][w_hit_way], w_ofst);
            u_ready <= 1'b1;
            r_state <= IDLE;
`ifdef L1_CACHE_STATS_EN
            hit_cnt <= sat_inc(hit_cnt);
`endif
          end else begin
            r_vict    <= w_vict;
            d_request <= 1'b1;
`ifdef L1_CACHE_STATS_EN
            miss_cnt <= sat_inc(miss_cnt);
`endif
            if (r_valid[w_idx][w_vict] && r_dirty[w_idx][w_vict]) begin
              d_we    <= 1'b1;
              d_addr  <= {r_tag[w_idx][w_vict], w_idx};
              d_din   <= r_data[w_idx][w_vict];
              r_state <= WRITEBACK;
`ifdef L1_CACHE_STATS_EN
              wb_cnt <= sat_inc(wb_cnt);
`endif
            end else begin
              d_we    <= 1'b0;
              d_addr  <= {w_tag, w_idx};
              r_state <= FILL;
            end
          end
        end
        WRITEBACK: if (d_ready) begin
          d_request <= 1'b1;
          d_we      <= 1'b0;
          d_addr    <= {w_tag, w_idx};
          r_state   <= FILL;
        end
        FILL: if (d_ready) begin
          r_valid[w_idx][r_vict] <= 1'b1;
          r_dirty[w_idx][r_vict] <= r_we;
          u_ready <= 1'b1;
          if (!r_we) u_dout <= get_word(d_dout, w_ofst);
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Request payload, tags and line data carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if ((r_state == IDLE) && u_request) begin
      r_addr <= u_addr;
      r_din  <= u_din;
    end
    if ((r_state == LOOKUP) && w_hit && r_we)
      r_data[w_idx][w_hit_way] <= merge_word(r_data[w_idx][w_hit_way], w_ofst, r_din);
    if ((r_state == FILL) && d_ready) begin
      r_data[w_idx][r_vict] <= r_we ? merge_word(d_dout, w_ofst, r_din) : d_dout;
      r_tag[w_idx][r_vict]  <= w_tag;
    end
  end

endmodule

// File: tb/tb_l1_cache_nway.sv
// Directed bench for l1_cache_nway at default parameters; define L1_CACHE_STATS_EN to also check counters.
module tb_l1_cache_nway;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        u_request = 1'b0;
  logic        u_we = 1'b0;
  logic [7:0]  u_addr = '0;
  logic [7:0]  u_din = '0;
  logic        u_ready;
  logic [7:0]  u_dout;
  logic        d_request;
  logic        d_we;
  logic [5:0]  d_addr;
  logic [31:0] d_din;
  logic        d_ready = 1'b0;
  logic [31:0] d_dout = '0;
`ifdef L1_CACHE_STATS_EN
  logic [15:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  int total = 0;
  int bad   = 0;

  l1_cache_nway dut (
    .clk(clk), .rst_n(rst_n),
    .u_request(u_request), .u_we(u_we), .u_addr(u_addr), .u_din(u_din),
    .u_ready(u_ready), .u_dout(u_dout),
    .d_request(d_request), .d_we(d_we), .d_addr(d_addr), .d_din(d_din),
    .d_ready(d_ready), .d_dout(d_dout)
`ifdef L1_CACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Ends at the negedge after the accepting posedge (DUT in LOOKUP).
  task automatic start(input logic we, input logic [7:0] addr, input logic [7:0] din);
    @(negedge clk);
    u_request = 1'b1; u_we = we; u_addr = addr; u_din = din;
    @(negedge clk);
    u_request = 1'b0; u_we = 1'b0; u_addr = 8'hFF; u_din = 8'hFF;
  endtask

  task automatic give_dready(input logic [31:0] blk);
    d_dout = blk; d_ready = 1'b1;
    @(negedge clk);
    d_ready = 1'b0; d_dout = 32'hDEADBEEF;
  endtask

  task automatic read_hit(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    start(1'b0, addr, 8'h00);
    @(negedge clk);
    chk({tag, "_rdy"}, u_ready, 1);
    chk({tag, "_dout"}, u_dout, exp);
    chk({tag, "_nodreq"}, d_request, 0);
  endtask

  task automatic miss_fill(input string tag, input logic we, input logic [7:0] addr,
                           input logic [7:0] din, input logic [31:0] blk, input logic [7:0] exp);
    start(we, addr, din);
    @(negedge clk);
    chk({tag, "_dreq"}, d_request, 1);
    chk({tag, "_dwe"}, d_we, 0);
    chk({tag, "_daddr"}, d_addr, {26'd0, addr[7:2]});
    give_dready(blk);
    chk({tag, "_rdy"}, u_ready, 1);
    if (!we) chk({tag, "_dout"}, u_dout, exp);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_ready", u_ready, 0);
    chk("rst_dout", u_dout, 0);
    chk("rst_dreq", d_request, 0);
    chk("rst_dwe", d_we, 0);
    chk("rst_daddr", d_addr, 0);
    chk("rst_ddin", d_din, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Test 1: cold miss then hit in the same block
    miss_fill("t1_miss", 1'b0, 8'h10, 8'h00, 32'h44332211, 8'h11);
    @(negedge clk);
    chk("t1_idle_rdy", u_ready, 0);
    chk("t1_idle_dout", u_dout, 0);
    read_hit("t1_hit", 8'h13, 8'h44);

    // Test 2: dirty eviction writes back before filling
    do_reset();
    miss_fill("t2_wr", 1'b1, 8'h01, 8'hAB, 32'h00000000, 8'h00);
    miss_fill("t2_r10", 1'b0, 8'h10, 8'h00, 32'h13121110, 8'h10);
    miss_fill("t2_r20", 1'b0, 8'h20, 8'h00, 32'h23222120, 8'h20);
    miss_fill("t2_r30", 1'b0, 8'h30, 8'h00, 32'h33323130, 8'h30);
    start(1'b0, 8'h40, 8'h00);
    @(negedge clk);
    chk("t2_wb_dreq", d_request, 1);
    chk("t2_wb_dwe", d_we, 1);
    chk("t2_wb_daddr", d_addr, 6'h00);
    chk("t2_wb_ddin", d_din, 32'h0000AB00);
    give_dready(32'h0);
    chk("t2_fill_dreq", d_request, 1);
    chk("t2_fill_dwe", d_we, 0);
    chk("t2_fill_daddr", d_addr, 6'h10);
    chk("t2_fill_nordy", u_ready, 0);
    give_dready(32'h43424140);
    chk("t2_done_rdy", u_ready, 1);
    chk("t2_done_dout", u_dout, 8'h40);
`ifdef L1_CACHE_STATS_EN
    chk("t6_hit_cnt", hit_cnt, 0);
    chk("t6_miss_cnt", miss_cnt, 5);
    chk("t6_wb_cnt", wb_cnt, 1);
`endif
    read_hit("t2_r10_hit", 8'h10, 8'h10);

    // Test 3: LRU evicts tag 1 after tag 0 was re-touched
    do_reset();
    miss_fill("t3_f00", 1'b0, 8'h00, 8'h00, 32'h03020100, 8'h00);
    miss_fill("t3_f10", 1'b0, 8'h10, 8'h00, 32'h13121110, 8'h10);
    miss_fill("t3_f20", 1'b0, 8'h20, 8'h00, 32'h23222120, 8'h20);
    miss_fill("t3_f30", 1'b0, 8'h30, 8'h00, 32'h33323130, 8'h30);
    read_hit("t3_h00", 8'h00, 8'h00);
    miss_fill("t3_f40", 1'b0, 8'h41, 8'h00, 32'h43424140, 8'h41);
    read_hit("t3_h00b", 8'h02, 8'h02);
    read_hit("t3_h20", 8'h23, 8'h23);
    miss_fill("t3_m10", 1'b0, 8'h10, 8'h00, 32'h13121110, 8'h10);

    // Test 4: reset during FILL abandons the transfer and invalidates lines
    do_reset();
    miss_fill("t4_f00", 1'b0, 8'h00, 8'h00, 32'hDDCCBBAA, 8'hAA);
    read_hit("t4_h00", 8'h00, 8'hAA);
    start(1'b0, 8'h20, 8'h00);
    @(negedge clk);
    chk("t4_dreq", d_request, 1);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_dreq", d_request, 0);
    chk("t4_rst_daddr", d_addr, 0);
    chk("t4_rst_dwe", d_we, 0);
    chk("t4_rst_rdy", u_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    give_dready(32'h23222120);
    chk("t4_late_rdy", u_ready, 0);
    chk("t4_late_dreq", d_request, 0);
    miss_fill("t4_m00", 1'b0, 8'h00, 8'h00, 32'hDDCCBBAA, 8'hAA);

    // Test 5: held request with stray d_ready gives u_ready every 2nd cycle
    @(negedge clk);
    u_request = 1'b1; u_we = 1'b0; u_addr = 8'h02; d_ready = 1'b1; d_dout = 32'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("t5_rdy%0d", i), u_ready, (i % 2 == 1) ? 1 : 0);
      chk($sformatf("t5_dout%0d", i), u_dout, (i % 2 == 1) ? 8'hCC : 8'h00);
      chk($sformatf("t5_dreq%0d", i), d_request, 0);
    end
    u_request = 1'b0; d_ready = 1'b0;
    @(negedge clk);

    // Write hit then read back the merged word and neighbour
    start(1'b1, 8'h03, 8'h5A);
    @(negedge clk);
    chk("wh_rdy", u_ready, 1);
    chk("wh_nodreq", d_request, 0);
    read_hit("wh_rd3", 8'h03, 8'h5A);
    read_hit("wh_rd1", 8'h01, 8'hBB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
